// File: rtl/wb_ddr3_port_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | wb_ddr3_port_arbiter: two Wishbone masters onto one DDR3 bridge port,    |
// | round-robin tie-break, stall watchdog.                  Revision: 1.0    |
// +--------------------------------------------------------------------------+
module wb_ddr3_port_arbiter #(
  parameter int WB_AWIDTH = 32,
  parameter int WB_DWIDTH = 32,
  parameter int TIMEOUT   = 255
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [WB_AWIDTH-1:0]   m0_adr,
  input  logic [WB_DWIDTH/8-1:0] m0_sel,
  input  logic                   m0_we,
  input  logic [WB_DWIDTH-1:0]   m0_dat_w,
  input  logic                   m0_cyc,
  input  logic                   m0_stb,
  output logic [WB_DWIDTH-1:0]   m0_dat_r,
  output logic                   m0_ack,
  output logic                   m0_err,
  input  logic [WB_AWIDTH-1:0]   m1_adr,
  input  logic [WB_DWIDTH/8-1:0] m1_sel,
  input  logic                   m1_we,
  input  logic [WB_DWIDTH-1:0]   m1_dat_w,
  input  logic                   m1_cyc,
  input  logic                   m1_stb,
  output logic [WB_DWIDTH-1:0]   m1_dat_r,
  output logic                   m1_ack,
  output logic                   m1_err,
  output logic [WB_AWIDTH-1:0]   s_adr,
  output logic [WB_DWIDTH/8-1:0] s_sel,
  output logic                   s_we,
  output logic [WB_DWIDTH-1:0]   s_dat_w,
  output logic                   s_cyc,
  output logic                   s_stb,
  input  logic [WB_DWIDTH-1:0]   s_dat_r,
  input  logic                   s_ack,
  input  logic                   s_err,
  output logic [1:0]             grant,
  output logic                   timeout_pulse
);

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  grant_q, grant_d;
  logic        last_owner_q, last_owner_d;
  logic [15:0] cnt_q, cnt_d;
  logic        arm_q, arm_d;

  logic        owned;
  logic        own_cyc;
  logic        own_stb;
  logic        own0;
  logic        own1;
  logic        fire;

  always_comb begin
    owned   = 1'b0;
    own_cyc = 1'b0;
    own_stb = 1'b0;
    s_adr   = '0;
    s_sel   = '0;
    s_we    = 1'b0;
    s_dat_w = '0;
    case (state_q)
      OWN0: begin
        owned   = 1'b1;
        own_cyc = m0_cyc;
        own_stb = m0_stb;
        s_adr   = m0_adr;
        s_sel   = m0_sel;
        s_we    = m0_we;
        s_dat_w = m0_dat_w;
      end
      OWN1: begin
        owned   = 1'b1;
        own_cyc = m1_cyc;
        own_stb = m1_stb;
        s_adr   = m1_adr;
        s_sel   = m1_sel;
        s_we    = m1_we;
        s_dat_w = m1_dat_w;
      end
      default: ;
    endcase
  end

  // The armed cycle is the forced-termination cycle; the strobe is withdrawn then.
  assign s_cyc = own_cyc;
  assign s_stb = own_stb & ~arm_q;

  assign own0 = (state_q == OWN0);
  assign own1 = (state_q == OWN1);
  assign fire = arm_q & owned & ~s_ack;

  assign m0_dat_r      = s_dat_r;
  assign m1_dat_r      = s_dat_r;
  assign m0_ack        = own0 & s_ack;
  assign m1_ack        = own1 & s_ack;
  assign m0_err        = own0 & (s_err | fire);
  assign m1_err        = own1 & (s_err | fire);
  assign grant         = grant_q;
  assign timeout_pulse = fire;

  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
    case (state_q)
      IDLE: begin
        if (m0_cyc && m1_cyc) begin
          if (last_owner_q) begin
            state_d      = OWN0;
            last_owner_d = 1'b0;
          end else begin
            state_d      = OWN1;
            last_owner_d = 1'b1;
          end
        end else if (m0_cyc) begin
          state_d      = OWN0;
          last_owner_d = 1'b0;
        end else if (m1_cyc) begin
          state_d      = OWN1;
          last_owner_d = 1'b1;
        end
      end
      OWN0:    if (!m0_cyc) state_d = IDLE;
      OWN1:    if (!m1_cyc) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    grant_d = {state_d == OWN1, state_d == OWN0};
  end

  // Arm only while the owner keeps its cycle, so a pulse never lands in IDLE.
  always_comb begin
    arm_d = owned && own_cyc && own_stb && !s_ack && !s_err && !arm_q &&
            (cnt_q == TO_LAST);
    if (!owned || !own_cyc || s_ack || s_err || arm_q) begin
      cnt_d = '0;
    end else if (s_stb) begin
      cnt_d = cnt_q + 16'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      grant_q      <= 2'b00;
      last_owner_q <= 1'b1;
      cnt_q        <= '0;
      arm_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_owner_q <= last_owner_d;
      cnt_q        <= cnt_d;
      arm_q        <= arm_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_wb_ddr3_port_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_wb_ddr3_port_arbiter: directed bench with termination scoreboard.     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_wb_ddr3_port_arbiter;

  logic        clk;
  logic        reset;
  logic [31:0] m0_adr, m1_adr, m0_dat_w, m1_dat_w, m0_dat_r, m1_dat_r;
  logic [3:0]  m0_sel, m1_sel;
  logic        m0_we, m1_we, m0_cyc, m1_cyc, m0_stb, m1_stb;
  logic        m0_ack, m1_ack, m0_err, m1_err;
  logic [31:0] s_adr, s_dat_w, s_dat_r;
  logic [3:0]  s_sel;
  logic        s_we, s_cyc, s_stb, s_ack, s_err;
  logic [1:0]  grant;
  logic        timeout_pulse;

  typedef struct packed {
    logic        m;
    logic        ack;
    logic        err;
    logic [31:0] dat;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;

  wb_ddr3_port_arbiter #(
    .WB_AWIDTH(32),
    .WB_DWIDTH(32),
    .TIMEOUT  (8)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .m0_adr       (m0_adr),
    .m0_sel       (m0_sel),
    .m0_we        (m0_we),
    .m0_dat_w     (m0_dat_w),
    .m0_cyc       (m0_cyc),
    .m0_stb       (m0_stb),
    .m0_dat_r     (m0_dat_r),
    .m0_ack       (m0_ack),
    .m0_err       (m0_err),
    .m1_adr       (m1_adr),
    .m1_sel       (m1_sel),
    .m1_we        (m1_we),
    .m1_dat_w     (m1_dat_w),
    .m1_cyc       (m1_cyc),
    .m1_stb       (m1_stb),
    .m1_dat_r     (m1_dat_r),
    .m1_ack       (m1_ack),
    .m1_err       (m1_err),
    .s_adr        (s_adr),
    .s_sel        (s_sel),
    .s_we         (s_we),
    .s_dat_w      (s_dat_w),
    .s_cyc        (s_cyc),
    .s_stb        (s_stb),
    .s_dat_r      (s_dat_r),
    .s_ack        (s_ack),
    .s_err        (s_err),
    .grant        (grant),
    .timeout_pulse(timeout_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Every ack/err seen at a master must match the oldest expected termination.
  task automatic sb_observe();
    for (int m = 0; m < 2; m++) begin
      logic ak;
      logic er;
      exp_t e;
      ak = (m == 0) ? m0_ack : m1_ack;
      er = (m == 0) ? m0_err : m1_err;
      if (ak || er) begin
        if (sb_q.size() == 0) begin
          chk("sb_unexpected", {62'd0, ak, er}, 64'd0);
        end else begin
          e = sb_q.pop_front();
          chk("sb_master", m[0], e.m);
          chk("sb_ack", ak, e.ack);
          chk("sb_err", er, e.err);
          chk("sb_dat", (m == 0) ? m0_dat_r : m1_dat_r, e.dat);
        end
      end
    end
  endtask

  task automatic half();
    @(negedge clk);
    sb_observe();
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    m0_adr = '0; m0_sel = '0; m0_we = 1'b0; m0_dat_w = '0; m0_cyc = 1'b0; m0_stb = 1'b0;
    m1_adr = '0; m1_sel = '0; m1_we = 1'b0; m1_dat_w = '0; m1_cyc = 1'b0; m1_stb = 1'b0;
    s_dat_r = '0; s_ack = 1'b0; s_err = 1'b0;

    #2;
    chk("rst_grant", grant, 2'b00);
    chk("rst_s_cyc", s_cyc, 1'b0);
    chk("rst_pulse", timeout_pulse, 1'b0);
    chk("rst_acks", {m0_ack, m0_err, m1_ack, m1_err}, 4'b0000);
    repeat (2) @(posedge clk);
    #3 reset = 1'b1;
    nxt();

    // Tie from reset: m0 first, then alternation with one idle cycle between owners.
    m0_cyc = 1'b1; m1_cyc = 1'b1;
    half(); chk("tie_lat_grant", grant, 2'b00); chk("tie_lat_scyc", s_cyc, 1'b0);
    nxt(); half(); chk("tie_first_m0", grant, 2'b01); chk("tie_scyc", s_cyc, 1'b1);
    nxt(); m0_cyc = 1'b0;
    half(); chk("tie_rel_hold", grant, 2'b01);
    nxt(); m0_cyc = 1'b1;
    half(); chk("tie_gap1", grant, 2'b00);
    nxt(); half(); chk("tie_second_m1", grant, 2'b10);
    nxt(); m1_cyc = 1'b0;
    half();
    nxt(); m1_cyc = 1'b1;
    half(); chk("tie_gap2", grant, 2'b00);
    nxt(); half(); chk("tie_third_m0", grant, 2'b01);
    nxt(); m0_cyc = 1'b0; m1_cyc = 1'b0;
    half();
    nxt(); half(); chk("tie_idle", grant, 2'b00);
    nxt();

    // Single write from m0.
    m0_cyc = 1'b1; m0_stb = 1'b1; m0_we = 1'b1; m0_adr = 32'h100;
    m0_dat_w = 32'hDEAD_BEEF; m0_sel = 4'hF;
    half(); chk("wr_lat_scyc", s_cyc, 1'b0); chk("wr_lat_sadr", s_adr, 32'h0);
    nxt(); half();
    chk("wr_grant", grant, 2'b01); chk("wr_s_adr", s_adr, 32'h100);
    chk("wr_s_we", s_we, 1'b1); chk("wr_s_stb", s_stb, 1'b1);
    chk("wr_s_dat_w", s_dat_w, 32'hDEAD_BEEF); chk("wr_s_sel", s_sel, 4'hF);
    nxt(); s_ack = 1'b1; s_dat_r = 32'h0000_1111;
    sb_q.push_back('{m: 1'b0, ack: 1'b1, err: 1'b0, dat: 32'h0000_1111});
    half(); chk("wr_m1_quiet", m1_ack, 1'b0);
    nxt(); s_ack = 1'b0; m0_cyc = 1'b0; m0_stb = 1'b0;
    half(); chk("wr_rel_hold", grant, 2'b01); chk("wr_rel_scyc", s_cyc, 1'b0);
    nxt(); half(); chk("wr_release", grant, 2'b00);
    nxt();

    // m1 read burst while m0 waits.
    m1_cyc = 1'b1; m1_stb = 1'b1; m1_we = 1'b0; m1_adr = 32'h200; m1_sel = 4'hF;
    half();
    nxt(); m0_cyc = 1'b1; m0_stb = 1'b1; m0_adr = 32'h300; m0_we = 1'b0;
    half(); chk("bu_grant0", grant, 2'b10);
    for (int i = 0; i < 4; i++) begin
      nxt(); s_ack = 1'b1; s_dat_r = 32'(32'hA000_0000 + i);
      sb_q.push_back('{m: 1'b1, ack: 1'b1, err: 1'b0, dat: s_dat_r});
      half();
      chk("bu_grant", grant, 2'b10); chk("bu_m0_ack", m0_ack, 1'b0);
      chk("bu_s_adr", s_adr, 32'h200);
    end
    nxt(); s_ack = 1'b0; m1_cyc = 1'b0; m1_stb = 1'b0;
    half(); chk("bu_rel_hold", grant, 2'b10);
    nxt(); half(); chk("bu_gap", grant, 2'b00);
    nxt(); m0_cyc = 1'b0; m0_stb = 1'b0;
    half(); chk("bu_handover", grant, 2'b01);
    nxt(); half(); nxt();

    // Bridge never answers: forced error 8 cycles after the strobe rises.
    m0_cyc = 1'b1; m0_stb = 1'b1; m0_we = 1'b1; m0_adr = 32'h400; s_dat_r = 32'h0;
    half();
    nxt(); half(); chk("to_stb_rise", s_stb, 1'b1);
    for (int i = 1; i < 8; i++) begin
      nxt(); half();
      chk("to_wait_pulse", timeout_pulse, 1'b0); chk("to_wait_stb", s_stb, 1'b1);
    end
    nxt();
    sb_q.push_back('{m: 1'b0, ack: 1'b0, err: 1'b1, dat: 32'h0});
    half();
    chk("to_pulse", timeout_pulse, 1'b1); chk("to_stb_low", s_stb, 1'b0);
    chk("to_err", m0_err, 1'b1);
    nxt(); m0_cyc = 1'b0; m0_stb = 1'b0;
    half(); chk("to_pulse_one", timeout_pulse, 1'b0);
    nxt(); half(); nxt();

    // Ack arrives in the timeout cycle: ack wins.
    m0_cyc = 1'b1; m0_stb = 1'b1; m0_we = 1'b0; m0_adr = 32'h500;
    half();
    nxt(); half();
    for (int i = 1; i < 8; i++) begin
      nxt(); half();
    end
    nxt(); s_ack = 1'b1; s_dat_r = 32'h0000_5555;
    sb_q.push_back('{m: 1'b0, ack: 1'b1, err: 1'b0, dat: 32'h0000_5555});
    half();
    chk("race_ack", m0_ack, 1'b1); chk("race_err", m0_err, 1'b0);
    chk("race_pulse", timeout_pulse, 1'b0);
    nxt(); s_ack = 1'b0; m0_cyc = 1'b0; m0_stb = 1'b0;
    half(); nxt(); half(); nxt();

    // Asynchronous reset while m1 has a strobe outstanding.
    m1_cyc = 1'b1; m1_stb = 1'b1; m1_adr = 32'h600;
    half();
    nxt(); half(); chk("rs_grant", grant, 2'b10); chk("rs_stb", s_stb, 1'b1);
    #1 reset = 1'b0; s_ack = 1'b1; s_dat_r = 32'h0000_0BAD;
    #1;
    chk("rs_async_grant", grant, 2'b00); chk("rs_async_scyc", s_cyc, 1'b0);
    chk("rs_async_sstb", s_stb, 1'b0); chk("rs_async_sadr", s_adr, 32'h0);
    chk("rs_async_ack", m1_ack, 1'b0); chk("rs_async_pulse", timeout_pulse, 1'b0);
    s_ack = 1'b0;
    nxt(); chk("rs_held", grant, 2'b00);
    m0_cyc = 1'b1; m1_cyc = 1'b1; m1_stb = 1'b0; reset = 1'b1;
    half(); chk("rs_post_idle", grant, 2'b00);
    nxt(); half(); chk("rs_tie_m0", grant, 2'b01);
    nxt(); m0_cyc = 1'b0; m1_cyc = 1'b0;
    half(); nxt(); half(); nxt();

    chk("sb_empty", sb_q.size(), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/wb_ddr3_port_arbiter.md
WB_DDR3_PORT_ARBITER -- requirements
Module: wb_ddr3_port_arbiter

Interface
REQ-001 Parameter WB_AWIDTH, default 32: Wishbone address width.
REQ-002 Parameter WB_DWIDTH, default 32: Wishbone data width.
REQ-003 Parameter TIMEOUT, default 255: slave stall cycles before forced error; legal range 2..65535.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset; low forces reset state immediately, deassertion is sampled on clk.
REQ-006 m0_adr / m1_adr  input  WB_AWIDTH  master address.
REQ-007 m0_sel / m1_sel  input  WB_DWIDTH/8  byte selects.
REQ-008 m0_we / m1_we  input  1  write enable.
REQ-009 m0_dat_w / m1_dat_w  input  WB_DWIDTH  write data.
REQ-010 m0_cyc / m1_cyc, m0_stb / m1_stb  input  1  bus cycle / strobe.
REQ-011 m0_dat_r / m1_dat_r  output  WB_DWIDTH  read data (s_dat_r fanned out to both).
REQ-012 m0_ack / m1_ack, m0_err / m1_err  output  1  termination, owner only.
REQ-013 s_adr, s_sel, s_we, s_dat_w, s_cyc, s_stb  output  as master  to DDR3 bridge.
REQ-014 s_dat_r  input  WB_DWIDTH; s_ack, s_err  input  1  bridge response.
REQ-015 grant  output  2  one-hot current owner (bit n = master n), 00 when idle.
REQ-016 timeout_pulse  output  1  one-cycle pulse on forced termination.

Function
REQ-017 FSM states IDLE, OWN0, OWN1, held in registers; grant is a registered decode of state.
REQ-018 IDLE: if exactly one mN_cyc high -> OWNn next cycle; if both high -> master other than last_owner; neither -> stay IDLE.
REQ-019 last_owner register updates on each IDLE->OWNn transition; resets to 1 so m0 wins first tie.
REQ-020 OWNn: s_adr/s_sel/s_we/s_dat_w/s_cyc/s_stb combinationally follow master n; in IDLE all s_* outputs are 0.
REQ-021 OWNn: mN_ack = s_ack, mN_err = s_err, non-owner ack/err held 0.
REQ-022 OWNn -> IDLE on cycle mN_cyc samples low; exactly one idle cycle between owners (no back-to-back handover).
REQ-023 Burst: owner keeps the port across multiple stb/ack while mN_cyc stays high; other master is starved until release.
REQ-024 Watchdog: 16-bit counter increments each cycle s_stb high with s_ack and s_err low; clears on ack, err, or leaving OWNn.
REQ-025 Counter reaching TIMEOUT-1 with no response: next cycle mN_err=1 and timeout_pulse=1 for one cycle, s_stb forced 0 that cycle, counter clears.
REQ-026 s_ack and timeout coinciding: s_ack wins, no err, no pulse.
REQ-027 s_ack and s_err both high: forwarded unchanged, counter clears.
REQ-028 Latency: mN_cyc rising in IDLE -> s_cyc high on following cycle (1-cycle grant latency).

Reset
REQ-029 reset low: state IDLE, grant 00, last_owner 1, counter 0, timeout_pulse 0, all s_* and mN_ack/mN_err 0.
REQ-030 reset asserted mid-transaction: port dropped immediately; no ack delivered; after release both masters re-arbitrate from IDLE.

Verification
REQ-031 m0_cyc/stb high alone, write adr 0x100 -> next cycle grant=01, s_adr=0x100, s_we=1; s_ack routed to m0_ack only; m0_cyc low -> grant=00 next cycle.
REQ-032 Both cyc high from reset -> m0 granted first; m0 releases -> one idle cycle -> grant=10; repeat -> alternates 01,10,01.
REQ-033 m1 owns, 4-beat read burst with m0_cyc held high -> grant stays 10 for all 4 acks, m0_ack never asserts.
REQ-034 TIMEOUT=8, bridge never acks -> m0_err and timeout_pulse high exactly 8 cycles after s_stb rose, s_stb low that cycle.
REQ-035 s_ack on same cycle as timeout -> m0_ack=1, m0_err=0, timeout_pulse=0.
REQ-036 reset pulled low while grant=10 with stb outstanding -> all outputs 0 asynchronously; post-release m0 tie-break restored.
